// File: rtl/folded_threshold_unit.sv
// Folded popcount/threshold unit: reduces an N-bit vector W bits per cycle and
// reports the popcount plus a (count >= thresh) decision over valid/ready.
module folded_threshold_unit #(
  parameter int N = 51,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             in_vec,
  input  logic [$clog2(N+1)-1:0]   thresh,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(N+1)-1:0]   out_count,
  output logic                     out_y
);

  localparam int CW = $clog2(N + 1);
  localparam int C  = (N + W - 1) / W;
  localparam int VW = C * W;
  localparam int KW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ACC = 2'd1, DONE = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [VW-1:0]   vec_r;
  logic [CW-1:0]   thresh_r;
  logic [CW-1:0]   acc_r;
  logic [KW-1:0]   k_r;
  logic [CW-1:0]   count_r;
  logic            y_r;
  logic            valid_r;
  logic            accept_s;
  logic            last_s;
  logic [CW-1:0]   sum_s;
  logic            ready_s;

  function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < W; i++) begin
      s = s + CW'(v[i]);
    end
    return s;
  endfunction

  // Handshake and per-cycle accumulation terms; the vector register is shifted
  // so the current chunk always sits in the low W bits (zero-padded tail).
  always_comb begin
    ready_s  = ~rst & ((state_r == IDLE) | ((state_r == DONE) & out_ready));
    accept_s = in_valid & ready_s;
    last_s   = (k_r == KW'(C - 1));
    sum_s    = acc_r + popcount(vec_r[W-1:0]);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = ACC;
        else          state_s = IDLE;
      end
      ACC: begin
        if (last_s) state_s = DONE;
        else        state_s = ACC;
      end
      DONE: begin
        if (accept_s)       state_s = ACC;
        else if (out_ready) state_s = IDLE;
        else                state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Datapath: latch on accept, fold during ACC, capture result on the last chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_r    <= '0;
      thresh_r <= '0;
      acc_r    <= '0;
      k_r      <= '0;
      count_r  <= '0;
      y_r      <= 1'b0;
      valid_r  <= 1'b0;
    end else if (accept_s) begin
      vec_r    <= VW'(in_vec);
      thresh_r <= thresh;
      acc_r    <= '0;
      k_r      <= '0;
      valid_r  <= 1'b0;
    end else if (state_r == ACC) begin
      acc_r <= sum_s;
      vec_r <= vec_r >> W;
      k_r   <= k_r + KW'(1);
      if (last_s) begin
        count_r <= sum_s;
        y_r     <= (sum_s >= thresh_r);
        valid_r <= 1'b1;
      end
    end else if ((state_r == DONE) && out_ready) begin
      valid_r <= 1'b0;
    end
  end

  assign in_ready  = ready_s;
  assign out_valid = valid_r;
  assign out_count = count_r;
  assign out_y     = y_r;

endmodule

// File: tb/tb_folded_threshold_unit.sv
// Directed table plus corner-case sequences for N=51/W=8, and a random sweep
// over three other folding configurations running in parallel.
module tb_folded_threshold_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        rst_sw;
  logic        in_valid, in_ready, out_valid, out_ready, out_y;
  logic [50:0] in_vec;
  logic [5:0]  thresh, out_count;
  int          n_cmp = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  folded_threshold_unit #(.N(51), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vec(in_vec), .thresh(thresh), .out_valid(out_valid),
    .out_ready(out_ready), .out_count(out_count), .out_y(out_y)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Random sweep instances: (N,W) = (5,2), (8,8), (51,1)
  for (genvar g = 0; g < 3; g++) begin : sw
    localparam int SN  = (g == 0) ? 5 : (g == 1) ? 8 : 51;
    localparam int SW  = (g == 0) ? 2 : (g == 1) ? 8 : 1;
    localparam int NV  = (g == 2) ? 1000 : 2000;
    localparam int SCW = $clog2(SN + 1);
    localparam int SC  = (g == 0) ? 3 : (g == 1) ? 1 : 51;
    logic iv, ir, ov, ordy, oy, done;
    logic [SN-1:0]  vec;
    logic [SCW-1:0] th, oc;

    folded_threshold_unit #(.N(SN), .W(SW)) u (
      .clk(clk), .rst(rst_sw), .in_valid(iv), .in_ready(ir), .in_vec(vec),
      .thresh(th), .out_valid(ov), .out_ready(ordy), .out_count(oc), .out_y(oy)
    );

    initial begin
      int lat;
      logic [SN-1:0]  v;
      logic [SCW-1:0] t;
      iv = 1'b0; ordy = 1'b0; vec = '0; th = '0; done = 1'b0;
      wait (rst_sw == 1'b0);
      @(posedge clk); #1;
      for (int n = 0; n < NV; n++) begin
        v = SN'({$urandom(), $urandom()});
        t = SCW'($urandom_range(0, SN + 1));
        for (int b = 0; b < 20 && !ir; b++) begin @(posedge clk); #1; end
        vec = v; th = t; iv = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0; vec = ~v; th = ~t;
        lat = 0;
        while (!ov && lat < 100) begin @(posedge clk); #1; lat++; end
        chk("sweep_latency", lat, SC);
        chk("sweep_count", int'(oc), $countones(v));
        chk("sweep_y", int'(oy), ($countones(v) >= int'(t)) ? 1 : 0);
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    rst_sw = 1'b1;
    #23 rst_sw = 1'b0;
  end

  typedef struct {
    logic [50:0] vec;
    logic [5:0]  th;
    int          cnt;
    int          y;
  } vec_t;
  vec_t tbl[9];

  // Accept one vector; returns cycles from the accept edge to out_valid.
  task automatic run_vec(input logic [50:0] v, input logic [5:0] t, output int lat);
    for (int b = 0; b < 20 && !in_ready; b++) begin @(posedge clk); #1; end
    in_vec = v; thresh = t; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_vec = ~v; thresh = ~t;
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    int c26;
    logic y26;
    tbl[0] = '{51'h0,             6'd26, 0,  0};
    tbl[1] = '{51'h3FFFFFF,       6'd26, 26, 1};
    tbl[2] = '{51'h1FFFFFF,       6'd26, 25, 0};
    tbl[3] = '{51'h7000000000000, 6'd26, 3,  0};
    tbl[4] = '{51'h7FFFFFFFFFFFF, 6'd26, 51, 1};
    tbl[5] = '{51'h0,             6'd0,  0,  1};
    tbl[6] = '{51'h7FFFFFFFFFFFF, 6'd52, 51, 0};
    tbl[7] = '{51'h5555555555555, 6'd26, 26, 1};
    tbl[8] = '{51'h5555555555555, 6'd27, 26, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_vec = '0; thresh = '0;
    @(posedge clk); #1;
    chk("reset_in_ready", int'(in_ready), 0);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_count", int'(out_count), 0);
    chk("reset_out_y", int'(out_y), 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 9; i++) begin
      run_vec(tbl[i].vec, tbl[i].th, lat);
      chk($sformatf("vec%0d_latency", i), lat, 7);
      chk($sformatf("vec%0d_count", i), int'(out_count), tbl[i].cnt);
      chk($sformatf("vec%0d_y", i), int'(out_y), tbl[i].y);
      ack();
      chk($sformatf("vec%0d_valid_drop", i), int'(out_valid), 0);
    end

    // Backpressure in DONE, then back-to-back accept on release
    run_vec(51'h3FFFFFF, 6'd26, lat);
    c26 = int'(out_count); y26 = out_y;
    chk("bp_first_count", c26, 26);
    in_valid = 1'b1; in_vec = 51'h3FFFFFFF; thresh = 6'd26;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_count", int'(out_count), 26);
      chk("bp_hold_y", int'(out_y), 1);
      chk("bp_hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    #1 chk("b2b_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0; in_vec = '0; thresh = '0;
    chk("b2b_valid_drop", int'(out_valid), 0);
    chk("b2b_in_ready_acc", int'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    chk("b2b_latency", lat, 7);
    chk("b2b_count", int'(out_count), 30);
    chk("b2b_y", int'(out_y), 1);
    ack();

    // Reset during the third ACC cycle
    in_vec = 51'h7FFFFFFFFFFFF; thresh = 6'd26; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_count", int'(out_count), 0);
    chk("midrst_y", int'(out_y), 0);
    chk("midrst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    chk("midrst_no_stale", int'(out_valid), 0);
    run_vec(51'h3FFFFFFF, 6'd26, lat);
    chk("postrst_latency", lat, 7);
    chk("postrst_count", int'(out_count), 30);
    chk("postrst_y", int'(out_y), 1);
    ack();

    lat = 0;
    while (!(sw[0].done && sw[1].done && sw[2].done) && lat < 80000) begin
      @(posedge clk); lat++;
    end
    chk("sweep_finished", int'(sw[0].done && sw[1].done && sw[2].done), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
